// File: rtl/imem_boot_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Stream layout: HDR_BYTES of little-endian word count, then WORD_BYTES per word.
package imem_boot_pkg;

   typedef enum logic [2:0] {
      HDR_LO,
      HDR_HI,
      DATA,
      RUN,
      ERROR
   } state_t;

   localparam int unsigned HDR_BYTES  = 2;
   localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/imem_boot_loader_byte_packer.sv
// Packs a byte stream into little-endian 32-bit words; pulses o_word_valid
// combinationally on the handshake of each word's final byte.
module byte_packer
   import imem_boot_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        i_valid,
   input  logic [7:0]  i_data,
   input  logic        i_clear,
   output logic [31:0] o_word,
   output logic        o_word_valid
);

   logic [1:0]  r_lane;
   logic [23:0] r_shift;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_lane  <= '0;
         r_shift <= '0;
      end else if (i_clear) begin
         r_lane <= '0;
      end else if (i_valid) begin
         r_lane <= r_lane + 2'd1;
         case (r_lane)
            2'd0:    r_shift[7:0]   <= i_data;
            2'd1:    r_shift[15:8]  <= i_data;
            2'd2:    r_shift[23:16] <= i_data;
            default: ;
         endcase
      end
   end

   // The top byte is never stored; it is forwarded straight into the word.
   assign o_word_valid = i_valid && (r_lane == 2'(WORD_BYTES - 1));
   assign o_word       = {i_data, r_shift};

endmodule

// File: rtl/imem_boot_loader.sv
// Boot sequencer: receives a counted byte stream, writes packed words to
// instruction memory from word 0, then releases the core from reset.
module imem_boot_loader
   import imem_boot_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  s_valid,
   input  logic [7:0]            s_data,
   output logic                  s_ready,
   input  logic                  load_req,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [31:0]           imem_wdata,
   output logic                  core_rst_n,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   state_t                r_state;
   state_t                w_next;
   logic [15:0]           r_count;
   logic [ADDR_WIDTH:0]   r_word_idx;
   logic                  r_we;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [31:0]           r_wdata;
   logic                  r_released;

   logic                  w_hs;
   logic                  w_restart;
   logic                  w_pk_valid;
   logic                  w_word_valid;
   logic                  w_last_word;
   logic                  w_release;
   logic [15:0]           w_count_full;
   logic [31:0]           w_word;

   assign w_hs         = s_valid && s_ready;
   assign w_restart    = load_req && ((r_state == RUN) || (r_state == ERROR));
   assign w_pk_valid   = w_hs && (r_state == DATA);
   assign w_count_full = {s_data, r_count[7:0]};
   assign w_last_word  = w_word_valid && ((32'(r_word_idx) + 32'd1) == 32'(r_count));

   byte_packer u_packer (
      .clk          (clk),
      .rst          (rst),
      .i_valid      (w_pk_valid),
      .i_data       (s_data),
      .i_clear      (w_restart),
      .o_word       (w_word),
      .o_word_valid (w_word_valid)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= HDR_LO;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         HDR_LO: if (w_hs) w_next = HDR_HI;
         HDR_HI: begin
            if (w_hs) begin
               if (w_count_full == 16'd0)
                  w_next = RUN;
               else if (32'(w_count_full) > (32'd1 << ADDR_WIDTH))
                  w_next = ERROR;
               else
                  w_next = DATA;
            end
         end
         DATA:   if (w_last_word) w_next = RUN;
         RUN:    if (load_req) w_next = HDR_LO;
         ERROR:  if (load_req) w_next = HDR_LO;
         default: w_next = HDR_LO;
      endcase
   end

   // RUN is entered during the final write cycle; release waits for it to retire.
   always_comb begin
      s_ready   = (r_state == HDR_LO) || (r_state == HDR_HI) || (r_state == DATA);
      busy      = s_ready;
      err       = (r_state == ERROR);
      w_release = (r_state == RUN) && !r_we;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count    <= '0;
         r_word_idx <= '0;
         r_we       <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_released <= 1'b0;
      end else begin
         if ((r_state == HDR_LO) && w_hs) r_count[7:0]  <= s_data;
         if ((r_state == HDR_HI) && w_hs) r_count[15:8] <= s_data;
         if (w_restart)
            r_word_idx <= '0;
         else if (w_word_valid)
            r_word_idx <= r_word_idx + 1'b1;
         r_we <= w_word_valid;
         if (w_word_valid) begin
            r_addr  <= r_word_idx[ADDR_WIDTH-1:0];
            r_wdata <= w_word;
         end
         r_released <= w_release;
      end
   end

   assign imem_we    = r_we;
   assign imem_addr  = r_addr;
   assign imem_wdata = r_wdata;
   assign core_rst_n = w_release;
   assign done       = w_release && !r_released;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader (ADDR_WIDTH=2) against a
// stream-level reference model of expected writes, timing and memory image.
module tb_imem_boot_loader;

   localparam int unsigned AW    = 2;
   localparam int unsigned DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          s_valid;
   logic [7:0]    s_data;
   logic          s_ready;
   logic          load_req;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic          core_rst_n;
   logic          busy;
   logic          done;
   logic          err;

   always #5 clk = ~clk;

   imem_boot_loader #(.ADDR_WIDTH(AW)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .s_valid    (s_valid),
      .s_data     (s_data),
      .s_ready    (s_ready),
      .load_req   (load_req),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .core_rst_n (core_rst_n),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   typedef struct {
      int unsigned addr;
      logic [31:0] data;
      int unsigned cyc;
   } wr_t;

   int unsigned cyc = 0;
   wr_t         wr_q[$];
   int unsigned done_q[$];
   int unsigned rise_q[$];
   int unsigned err_q[$];
   logic        prev_rst_n = 1'b0;
   logic        prev_err   = 1'b0;
   logic [31:0] act_mem[DEPTH];
   logic [31:0] exp_mem[DEPTH];
   logic [7:0]  stream[$];
   int unsigned hs[$];
   int          n_tests = 0;
   int          n_fail  = 0;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (imem_we) begin
         wr_q.push_back('{addr: int'(imem_addr), data: imem_wdata, cyc: cyc});
         act_mem[imem_addr] = imem_wdata;
      end
      if (done) done_q.push_back(cyc);
      if (core_rst_n && !prev_rst_n) rise_q.push_back(cyc);
      if (err && !prev_err) err_q.push_back(cyc);
      prev_rst_n = core_rst_n;
      prev_err   = err;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_mon();
      wr_q.delete();
      done_q.delete();
      rise_q.delete();
      err_q.delete();
   endtask

   // Drives stream[]; bub_idx gets 3 idle cycles before it, req_at pulses load_req.
   task automatic send(input int bub_idx, input int unsigned bub_pct, input int req_at);
      logic rdy;
      int unsigned t;
      hs.delete();
      foreach (stream[i]) begin
         if (i == bub_idx) repeat (3) @(negedge clk);
         else if ($urandom_range(99) < bub_pct) repeat ($urandom_range(1, 3)) @(negedge clk);
         s_valid  = 1'b1;
         s_data   = stream[i];
         load_req = (i == req_at);
         t = 0;
         forever begin
            #1 rdy = s_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
               hs.push_back(cyc);
               break;
            end
            t++;
            @(negedge clk);
            if (t > 20) break;
         end
         if (t > 20) begin
            n_tests++;
            n_fail++;
            $error("FAIL hs_timeout: byte %0d not accepted, observed s_ready=0 expected 1", i);
            s_valid  = 1'b0;
            load_req = 1'b0;
            return;
         end
         @(negedge clk);
         s_valid  = 1'b0;
         load_req = 1'b0;
      end
   endtask

   task automatic check_load(input string tag);
      int unsigned n;
      int unsigned nw;
      int unsigned b;
      logic [31:0] w;
      n = {stream[1], stream[0]};
      repeat (4) @(negedge clk);
      nw = (n <= DEPTH) ? n : 0;
      chk({tag, "_nwr"}, wr_q.size(), nw);
      for (int unsigned k = 0; k < nw; k++) begin
         b = 2 + 4 * k;
         w = {stream[b+3], stream[b+2], stream[b+1], stream[b]};
         exp_mem[k] = w;
         if (k < wr_q.size()) begin
            chk({tag, "_waddr"}, wr_q[k].addr, k);
            chk({tag, "_wdata"}, wr_q[k].data, w);
            chk({tag, "_wcyc"},  wr_q[k].cyc, hs[b+3]);
         end
      end
      if (n > DEPTH) begin
         chk({tag, "_err"}, err, 1'b1);
         chk({tag, "_rdy"}, s_ready, 1'b0);
         chk({tag, "_crst"}, core_rst_n, 1'b0);
         chk({tag, "_nerr"}, err_q.size(), 1);
         if (err_q.size() > 0) chk({tag, "_errcyc"}, err_q[0], hs[1]);
      end else begin
         chk({tag, "_crst"}, core_rst_n, 1'b1);
         chk({tag, "_rdy"}, s_ready, 1'b0);
         chk({tag, "_busy"}, busy, 1'b0);
         chk({tag, "_err"}, err, 1'b0);
         chk({tag, "_nrise"}, rise_q.size(), 1);
         chk({tag, "_ndone"}, done_q.size(), 1);
         if (rise_q.size() > 0)
            chk({tag, "_risecyc"}, rise_q[0], (n == 0) ? hs[1] : hs[hs.size()-1] + 1);
         if (done_q.size() > 0 && rise_q.size() > 0)
            chk({tag, "_donecyc"}, done_q[0], rise_q[0]);
      end
      for (int unsigned k = 0; k < DEPTH; k++) chk({tag, "_mem"}, act_mem[k], exp_mem[k]);
   endtask

   task automatic restart(input string tag);
      @(negedge clk);
      load_req = 1'b1;
      @(negedge clk);
      load_req = 1'b0;
      chk({tag, "_rs_crst"}, core_rst_n, 1'b0);
      chk({tag, "_rs_rdy"}, s_ready, 1'b1);
      chk({tag, "_rs_busy"}, busy, 1'b1);
      chk({tag, "_rs_err"}, err, 1'b0);
   endtask

   task automatic set_words(input int unsigned n);
      stream.delete();
      stream.push_back(n[7:0]);
      stream.push_back(n[15:8]);
      if (n <= DEPTH)
         for (int unsigned i = 0; i < 4 * n; i++) stream.push_back(8'($urandom));
   endtask

   initial begin
      int unsigned n;
      int req_at;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         act_mem[k] = 32'hC0DE_0000 + k;
         exp_mem[k] = 32'hC0DE_0000 + k;
      end
      rst      = 1'b0;
      s_valid  = 1'b0;
      s_data   = '0;
      load_req = 1'b0;
      #1 rst = 1'b1;

      @(negedge clk);
      chk("rst_rdy",  s_ready,    1'b1);
      chk("rst_busy", busy,       1'b1);
      chk("rst_crst", core_rst_n, 1'b0);
      chk("rst_we",   imem_we,    1'b0);
      chk("rst_addr", imem_addr,  '0);
      chk("rst_wd",   imem_wdata, '0);
      chk("rst_err",  err,        1'b0);
      chk("rst_done", done,       1'b0);
      @(negedge clk);
      rst = 1'b0;

      clear_mon();
      stream = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
      send(-1, 0, -1);
      check_load("two_word");
      chk("two_word_w0", act_mem[0], 32'h0000_0013);
      chk("two_word_w1", act_mem[1], 32'h0010_0093);
      restart("two_word");

      clear_mon();
      send(4, 0, -1);
      check_load("bubble");
      restart("bubble");

      clear_mon();
      stream = '{8'h05, 8'h00};
      send(-1, 0, -1);
      check_load("over");
      restart("over");

      clear_mon();
      set_words(4);
      send(-1, 0, -1);
      check_load("full");
      restart("full");

      clear_mon();
      stream = '{8'h00, 8'h00};
      send(-1, 0, -1);
      check_load("zero");
      restart("zero");

      clear_mon();
      stream = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
      stream = stream[0:3];
      send(-1, 0, -1);
      #2 rst = 1'b1;
      #1;
      chk("midrst_we",   imem_we,    1'b0);
      chk("midrst_crst", core_rst_n, 1'b0);
      chk("midrst_rdy",  s_ready,    1'b1);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("midrst_nwr", wr_q.size(), 0);
      clear_mon();
      set_words(1);
      send(-1, 0, -1);
      check_load("after_rst");
      restart("after_rst");

      for (int unsigned it = 0; it < 10; it++) begin
         clear_mon();
         n = $urandom_range(0, DEPTH + 1);
         set_words(n);
         req_at = (n > 0 && n <= DEPTH) ? int'($urandom_range(2, stream.size() - 1)) : -1;
         send(-1, 30, req_at);
         check_load("rand");
         restart("rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
